// File: rtl/pulse_train_checker_if.sv
// Pulse link between a pulse source/monitor (master) and the pulse_train_checker (slave).
// The master drives the pulse train and observes the checker's lock/error/measurement outputs.
interface pulse_train_checker_if #(
    parameter int CW = 8
) ();
    logic          in;
    logic          locked;
    logic          err;
    logic [CW-1:0] period;
    logic [CW-1:0] pulse_cnt;

    modport master (
        output in,
        input  locked,
        input  err,
        input  period,
        input  pulse_cnt
    );

    modport slave (
        input  in,
        output locked,
        output err,
        output period,
        output pulse_cnt
    );
endinterface

// File: rtl/pulse_train_checker.sv
// Receive-side checker for a periodic single-cycle pulse train: measures pulse intervals,
// declares lock after LOCK_N consecutive correct intervals, and strobes err on short or missing pulses.
module pulse_train_checker #(
    parameter int PERIOD = 4,
    parameter int LOCK_N = 3,
    parameter int CW     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pulse_train_checker_if.slave  bus
);
    localparam int GW = $clog2(LOCK_N + 1);

    localparam logic [CW-1:0] PERIOD_V = CW'(PERIOD);
    localparam logic [CW-1:0] GAP_MAX  = {CW{1'b1}};
    localparam logic [GW-1:0] LOCK_V   = GW'(LOCK_N);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] gap_q, gap_d;
    logic [GW-1:0] good_q, good_d;
    logic [GW-1:0] good_inc;
    logic          err_q, err_d;
    logic          locked_q, locked_d;
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign good_inc = good_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        err_d    = 1'b0;
        period_d = period_q;
        cnt_d    = bus.in ? cnt_q + 1'b1 : cnt_q;

        // gap counts cycles since the last pulse; a pulse seen with gap == k is an interval of k
        if (bus.in) begin
            gap_d = {{(CW-1){1'b0}}, 1'b1};
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + 1'b1;
        end else begin
            gap_d = gap_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.in) begin
                    state_d = MEASURE;
                    good_d  = '0;
                end
            end
            MEASURE, LOCKED: begin
                if (bus.in) begin
                    if (gap_q == PERIOD_V) begin
                        period_d = PERIOD_V;
                        if (state_q == MEASURE) begin
                            if (good_inc >= LOCK_V) begin
                                good_d  = LOCK_V;
                                state_d = LOCKED;
                            end else begin
                                good_d = good_inc;
                            end
                        end
                    end else if (gap_q < PERIOD_V) begin
                        period_d = gap_q;
                        err_d    = 1'b1;
                        good_d   = '0;
                        state_d  = MEASURE;
                    end
                end else if (gap_q == PERIOD_V) begin
                    // Timeout: anything longer than PERIOD is reported as a missing pulse
                    err_d   = 1'b1;
                    good_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                good_d  = '0;
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gap_q    <= '0;
            good_q   <= '0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            period_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            good_q   <= good_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err       = err_q;
    assign bus.period    = period_q;
    assign bus.pulse_cnt = cnt_q;

endmodule

// File: tb/tb_pulse_train_checker.sv
// Directed testbench for pulse_train_checker (PERIOD=4, LOCK_N=3, CW=8); one task per scenario.
module tb_pulse_train_checker;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total = 0;
    int   err_seen = 0;
    int   lock_drop = 0;
    logic chk_lock = 1'b0;

    pulse_train_checker_if #(.CW(CW)) bus ();

    pulse_train_checker #(
        .PERIOD (4),
        .LOCK_N (3),
        .CW     (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of input, then sample 1 time unit after the edge.
    task automatic step(input logic v);
        bus.in = v;
        @(posedge clk);
        #1;
        if (bus.err) err_seen++;
        if (chk_lock && !bus.locked) lock_drop++;
    endtask

    // n-1 idle cycles followed by a pulse, i.e. a pulse n cycles after the previous one.
    task automatic pulse_after(input int n);
        repeat (n - 1) step(1'b0);
        step(1'b1);
        $display("pulse: locked=%0b err=%0b period=%0d pulse_cnt=%0d",
                 bus.locked, bus.err, bus.period, bus.pulse_cnt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        err_seen = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b1);
        step(1'b1);
        total++; if (bus.locked !== 1'b0) $display("FAIL reset_locked got=%0b exp=0", bus.locked); else passed++;
        total++; if (bus.err !== 1'b0) $display("FAIL reset_err got=%0b exp=0", bus.err); else passed++;
        total++; if (bus.period !== 8'd0) $display("FAIL reset_period got=%0d exp=0", bus.period); else passed++;
        total++; if (bus.pulse_cnt !== 8'd0) $display("FAIL reset_cnt got=%0d exp=0", bus.pulse_cnt); else passed++;
        rst = 1'b0;
        err_seen = 0;
    endtask

    task automatic test_lock();
        do_reset();
        pulse_after(1);
        total++; if (bus.period !== 8'd0) $display("FAIL lock_first_period got=%0d exp=0", bus.period); else passed++;
        pulse_after(4);
        pulse_after(4);
        total++; if (bus.locked !== 1'b0) $display("FAIL lock_early got=%0b exp=0", bus.locked); else passed++;
        pulse_after(4);
        total++; if (bus.locked !== 1'b1) $display("FAIL lock_locked got=%0b exp=1", bus.locked); else passed++;
        total++; if (bus.period !== 8'd4) $display("FAIL lock_period got=%0d exp=4", bus.period); else passed++;
        total++; if (bus.pulse_cnt !== 8'd4) $display("FAIL lock_cnt got=%0d exp=4", bus.pulse_cnt); else passed++;
        total++; if (err_seen !== 0) $display("FAIL lock_err_count got=%0d exp=0", err_seen); else passed++;
    endtask

    task automatic test_short();
        err_seen = 0;
        pulse_after(2);
        total++; if (bus.err !== 1'b1) $display("FAIL short_err got=%0b exp=1", bus.err); else passed++;
        total++; if (bus.locked !== 1'b0) $display("FAIL short_locked got=%0b exp=0", bus.locked); else passed++;
        total++; if (bus.period !== 8'd2) $display("FAIL short_period got=%0d exp=2", bus.period); else passed++;
        total++; if (bus.pulse_cnt !== 8'd5) $display("FAIL short_cnt got=%0d exp=5", bus.pulse_cnt); else passed++;
        step(1'b0);
        total++; if (bus.err !== 1'b0) $display("FAIL short_err_clear got=%0b exp=0", bus.err); else passed++;
        pulse_after(3);
        pulse_after(4);
        total++; if (bus.locked !== 1'b0) $display("FAIL short_relock_early got=%0b exp=0", bus.locked); else passed++;
        pulse_after(4);
        total++; if (bus.locked !== 1'b1) $display("FAIL short_relock got=%0b exp=1", bus.locked); else passed++;
        total++; if (bus.period !== 8'd4) $display("FAIL short_relock_period got=%0d exp=4", bus.period); else passed++;
        total++; if (bus.pulse_cnt !== 8'd8) $display("FAIL short_relock_cnt got=%0d exp=8", bus.pulse_cnt); else passed++;
        total++; if (err_seen !== 1) $display("FAIL short_err_count got=%0d exp=1", err_seen); else passed++;
    endtask

    task automatic test_missing();
        err_seen = 0;
        repeat (3) step(1'b0);
        total++; if (bus.err !== 1'b0) $display("FAIL miss_err_early got=%0b exp=0", bus.err); else passed++;
        total++; if (bus.locked !== 1'b1) $display("FAIL miss_locked_early got=%0b exp=1", bus.locked); else passed++;
        step(1'b0);
        total++; if (bus.err !== 1'b1) $display("FAIL miss_err got=%0b exp=1", bus.err); else passed++;
        total++; if (bus.locked !== 1'b0) $display("FAIL miss_locked got=%0b exp=0", bus.locked); else passed++;
        total++; if (bus.period !== 8'd4) $display("FAIL miss_period got=%0d exp=4", bus.period); else passed++;
        step(1'b0);
        total++; if (bus.err !== 1'b0) $display("FAIL miss_err_clear got=%0b exp=0", bus.err); else passed++;
        step(1'b1);
        total++; if (bus.err !== 1'b0) $display("FAIL miss_restart_err got=%0b exp=0", bus.err); else passed++;
        total++; if (bus.pulse_cnt !== 8'd9) $display("FAIL miss_restart_cnt got=%0d exp=9", bus.pulse_cnt); else passed++;
        pulse_after(4);
        pulse_after(4);
        total++; if (bus.locked !== 1'b0) $display("FAIL miss_relock_early got=%0b exp=0", bus.locked); else passed++;
        pulse_after(4);
        total++; if (bus.locked !== 1'b1) $display("FAIL miss_relock got=%0b exp=1", bus.locked); else passed++;
        total++; if (err_seen !== 1) $display("FAIL miss_err_count got=%0d exp=1", err_seen); else passed++;
    endtask

    task automatic test_continuous();
        do_reset();
        step(1'b1);
        total++; if (bus.err !== 1'b0) $display("FAIL cont_first_err got=%0b exp=0", bus.err); else passed++;
        repeat (5) step(1'b1);
        total++; if (err_seen !== 5) $display("FAIL cont_err_count got=%0d exp=5", err_seen); else passed++;
        total++; if (bus.err !== 1'b1) $display("FAIL cont_err got=%0b exp=1", bus.err); else passed++;
        total++; if (bus.pulse_cnt !== 8'd6) $display("FAIL cont_cnt got=%0d exp=6", bus.pulse_cnt); else passed++;
        total++; if (bus.period !== 8'd1) $display("FAIL cont_period got=%0d exp=1", bus.period); else passed++;
        total++; if (bus.locked !== 1'b0) $display("FAIL cont_locked got=%0b exp=0", bus.locked); else passed++;
        step(1'b0);
        total++; if (bus.err !== 1'b0) $display("FAIL cont_err_clear got=%0b exp=0", bus.err); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_after(1);
        repeat (3) pulse_after(4);
        total++; if (bus.locked !== 1'b1) $display("FAIL rmid_prelock got=%0b exp=1", bus.locked); else passed++;
        repeat (3) step(1'b0);
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        total++; if (bus.locked !== 1'b0) $display("FAIL rmid_locked got=%0b exp=0", bus.locked); else passed++;
        total++; if (bus.err !== 1'b0) $display("FAIL rmid_err got=%0b exp=0", bus.err); else passed++;
        total++; if (bus.period !== 8'd0) $display("FAIL rmid_period got=%0d exp=0", bus.period); else passed++;
        total++; if (bus.pulse_cnt !== 8'd0) $display("FAIL rmid_cnt got=%0d exp=0", bus.pulse_cnt); else passed++;
        err_seen = 0;
        pulse_after(1);
        pulse_after(4);
        pulse_after(4);
        total++; if (bus.locked !== 1'b0) $display("FAIL rmid_relock_early got=%0b exp=0", bus.locked); else passed++;
        pulse_after(4);
        total++; if (bus.locked !== 1'b1) $display("FAIL rmid_relock got=%0b exp=1", bus.locked); else passed++;
        total++; if (bus.pulse_cnt !== 8'd4) $display("FAIL rmid_relock_cnt got=%0d exp=4", bus.pulse_cnt); else passed++;
        total++; if (err_seen !== 0) $display("FAIL rmid_err_count got=%0d exp=0", err_seen); else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        pulse_after(1);
        repeat (3) pulse_after(4);
        total++; if (bus.locked !== 1'b1) $display("FAIL wrap_lock got=%0b exp=1", bus.locked); else passed++;
        lock_drop = 0;
        chk_lock = 1'b1;
        repeat (252) pulse_after(4);
        chk_lock = 1'b0;
        total++; if (lock_drop !== 0) $display("FAIL wrap_lock_drops got=%0d exp=0", lock_drop); else passed++;
        total++; if (err_seen !== 0) $display("FAIL wrap_err_count got=%0d exp=0", err_seen); else passed++;
        total++; if (bus.pulse_cnt !== 8'd0) $display("FAIL wrap_cnt got=%0d exp=0", bus.pulse_cnt); else passed++;
        total++; if (bus.locked !== 1'b1) $display("FAIL wrap_locked_end got=%0b exp=1", bus.locked); else passed++;
    endtask

    initial begin
        bus.in = 1'b0;
        test_reset();
        test_lock();
        test_short();
        test_missing();
        test_continuous();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pulse_train_checker.md
# pulse_train_checker

Receive-side checker for the periodic single-cycle pulse train produced by the team's start-triggered pulse counter. Samples a pulse input every clock and measures the interval between pulses. Declares lock after a run of correct intervals and flags short intervals and missing pulses. Sits at the consuming end of the pulse link, where it gives downstream logic a qualified "train present and correct" indication.

## Interface
- PERIOD, 4, expected pulse interval in clock cycles; 2 ≤ PERIOD < 2^CW
- LOCK_N, 3, consecutive correct intervals required to assert lock; ≥ 1
- CW, 8, width of interval and pulse counters
- clk  input  1  single clock, all logic on posedge
- rst  input  1  reset, synchronous and active-high; overrides all other inputs
- in  input  1  pulse train; each cycle sampled high is one pulse event
- locked  output  1  high while the checker is in LOCKED
- err  output  1  one-cycle error strobe (short interval or missing pulse)
- period  output  CW  most recently measured interval
- pulse_cnt  output  CW  pulses accepted since reset, wraps modulo 2^CW

## Operation
- Internal state: FSM {IDLE, MEASURE, LOCKED}, gap counter (CW bits), good counter (saturates at LOCK_N).
- gap: on a pulse, load 1; otherwise increment, saturating at 2^CW−1. A pulse seen with gap == k means an interval of k cycles.
- Every pulse outside reset increments pulse_cnt.
- IDLE:
  - A pulse moves the FSM to MEASURE and sets good = 0.
  - period is unchanged and err stays 0.
- MEASURE and LOCKED, pulse with gap == PERIOD:
  - Good interval; period ← PERIOD.
  - In MEASURE, good increments. When good reaches LOCK_N, the FSM enters LOCKED on the same edge.
- MEASURE and LOCKED, pulse with gap < PERIOD:
  - Short interval; period ← gap, err ← 1, good ← 0.
  - FSM goes to MEASURE. The pulse still restarts gap.
- MEASURE and LOCKED, in == 0 with gap == PERIOD:
  - Missing pulse; err ← 1, good ← 0, FSM goes to IDLE.
  - period is unchanged.
  - Long intervals are therefore always reported as missing pulses, never as measured intervals.
- locked = (state == LOCKED). err is registered, and every cause of err deasserts it after exactly one cycle.
- Reset value of each output: locked 0, err 0, period 0, pulse_cnt 0. Reset also sets FSM to IDLE, gap 0, good 0.

## Timing
- All outputs are registered. An event sampled on edge t is visible after edge t, with one-cycle latency.
- Lock latency: lock asserts after the edge sampling pulse number LOCK_N+1. For the default generator output (pulses 4 cycles apart), that is 12 cycles after the first pulse.
- Simultaneous events:
  - A pulse with gap == PERIOD is a good interval, not a timeout.
  - rst together with a pulse: reset wins; the pulse is not counted and not measured.
- Reset mid-operation, in any state: the next cycle shows all reset values. The first pulse after reset is treated as a pulse from IDLE.
- Continuous in = 1: every pulse after the first is a short interval (gap = 1). err stays high every cycle from the second pulse on.
- pulse_cnt wraps from 2^CW−1 to 0 with no flag.

## Test plan
- Default params. Release rst, then pulses at cycles 2, 6, 10, 14 → after edge 14: locked = 1, period = 4, pulse_cnt = 4, err never asserted.
- Locked; next pulse arrives 2 cycles after the previous one → err high for 1 cycle, locked = 0, period = 2. Three further pulses 4 apart → locked = 1 again.
- Locked; no pulse for 4 cycles after the last one → err high for 1 cycle on the edge where gap == 4, locked = 0, period stays 4. A later pulse → no err, pulse_cnt + 1, measuring restarts.
- in held high for 6 cycles from reset → pulse_cnt = 6, period = 1, err high for 5 consecutive cycles, locked = 0.
- While locked, assert rst on a pulse cycle → next cycle: locked = 0, err = 0, period = 0, pulse_cnt = 0. A pulse train 4 apart after reset relocks after 4 pulses.
- 256 pulses spaced 4 apart with CW = 8 → pulse_cnt = 0, locked = 1 throughout after the 4th pulse, no err.
